s9234_n466_sig_compactor: RTL and testbench

- Sequential response-capture stage directly downstream of the combinational s9234 n466 cone.
- Consumes one n466 bit per accepted test pattern and folds it into a serial signature register (SISR) plus a ones counter.
- After a programmed pattern count it compares the signature against an expected value and reports pass/fail.
- Lets the n466 partial output be checked over long pattern runs without storing per-pattern responses.

---
 rtl/s9234_n466_sig_compactor.sv | 102 ++++++++++
 tb/tb_s9234_n466_sig_compactor.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/s9234_n466_sig_compactor.sv
// Response-capture stage for the s9234 n466 cone: folds one bit per accepted
// pattern into a serial signature register, counts ones, and grades the run.
module s9234_n466_sig_compactor #(
  parameter int                SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED  = 16'h0000,
  parameter int                CNT_W = 16
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_patterns,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             n466,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] pat_cnt,
  output logic [CNT_W-1:0] ones_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [SIG_W-1:0] sig_q, exp_q, sig_d;
  logic [CNT_W-1:0] pat_q, ones_q, tgt_q, pat_d, ones_d;
  logic             pass_q;
  logic             fb;

  assign fb     = sig_q[SIG_W-1] ^ n466;
  assign sig_d  = {sig_q[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign pat_d  = pat_q + CNT_W'(1);
  // Ones counter sticks at all-ones rather than wrapping on long runs.
  assign ones_d = (&ones_q) ? ones_q : ones_q + CNT_W'(n466);

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= IDLE;
      sig_q   <= '0;
      pat_q   <= '0;
      ones_q  <= '0;
      tgt_q   <= '0;
      exp_q   <= '0;
      pass_q  <= 1'b0;
    end else if (abort) begin
      // Counters and signature are left intact for post-mortem inspection.
      state_q <= IDLE;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            sig_q  <= SEED;
            pat_q  <= '0;
            ones_q <= '0;
            tgt_q  <= num_patterns;
            exp_q  <= exp_sig;
            if (num_patterns == '0) begin
              state_q <= DONE;
              pass_q  <= (SEED == exp_sig);
            end else begin
              state_q <= RUN;
              pass_q  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (in_valid) begin
            sig_q  <= sig_d;
            pat_q  <= pat_d;
            ones_q <= ones_d;
            if (pat_d == tgt_q) begin
              state_q <= DONE;
              pass_q  <= (sig_d == exp_q);
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == RUN);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_cnt   = pat_q;
  assign ones_cnt  = ones_q;

endmodule

// File: tb/tb_s9234_n466_sig_compactor.sv
// Bench for the n466 signature compactor: directed plan steps then random
// traffic, all graded against a queue-based run model.
module tb_s9234_n466_sig_compactor;
  localparam int SIG_W = 16;
  localparam int CNT_W = 16;
  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] SEED = 16'h0000;

  logic CK = 1'b0;
  logic RST, start, abort, in_valid, n466;
  logic [CNT_W-1:0] num_patterns;
  logic [SIG_W-1:0] exp_sig;
  logic in_ready, busy, done, pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt, ones_cnt;

  s9234_n466_sig_compactor #(.SIG_W(SIG_W), .POLY(POLY), .SEED(SEED), .CNT_W(CNT_W)) dut (
    .CK(CK), .RST(RST), .start(start), .abort(abort),
    .num_patterns(num_patterns), .exp_sig(exp_sig),
    .in_valid(in_valid), .in_ready(in_ready), .n466(n466),
    .busy(busy), .done(done), .pass(pass), .signature(signature),
    .pat_cnt(pat_cnt), .ones_cnt(ones_cnt)
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;

  // Run model: mode 0=idle 1=run 2=done; bits holds every accepted response.
  int          m_mode = 0;
  bit          m_bits[$];
  int unsigned m_base = 0;
  int unsigned m_target = 0;
  int unsigned m_exp = 0;
  bit          m_pass = 0;

  function automatic int unsigned model_sig();
    int unsigned v = m_base;
    foreach (m_bits[i]) begin
      int unsigned fb = ((v / 32768) % 2) ^ int'(m_bits[i]);
      v = ((v * 2) % 65536) ^ (fb != 0 ? int'(POLY) : 0);
    end
    return v;
  endfunction

  function automatic int unsigned model_ones();
    int unsigned n = 0;
    foreach (m_bits[i]) if (m_bits[i]) n++;
    return (n > 65535) ? 65535 : n;
  endfunction

  task automatic model_step();
    if (RST) begin
      m_mode = 0; m_bits.delete(); m_base = 0;
      m_target = 0; m_exp = 0; m_pass = 0;
    end else if (abort) begin
      m_mode = 0; m_pass = 0;
    end else if ((m_mode == 0 || m_mode == 2) && start) begin
      m_base = SEED; m_bits.delete();
      m_target = num_patterns; m_exp = exp_sig; m_pass = 0;
      if (m_target == 0) begin
        m_mode = 2; m_pass = (int'(SEED) == m_exp);
      end else m_mode = 1;
    end else if (m_mode == 1 && in_valid) begin
      m_bits.push_back(n466);
      if (m_bits.size() == m_target) begin
        m_mode = 2; m_pass = (model_sig() == m_exp);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'(m_mode == 1));
    check({tag, "_busy"},     32'(busy),     32'(m_mode == 1));
    check({tag, "_done"},     32'(done),     32'(m_mode == 2));
    check({tag, "_pass"},     32'(pass),     32'(m_pass));
    check({tag, "_sig"},      32'(signature), model_sig());
    check({tag, "_pat_cnt"},  32'(pat_cnt),  m_bits.size());
    check({tag, "_ones_cnt"}, 32'(ones_cnt), model_ones());
  endtask

  // One clock: model advances on the same edge as the DUT, outputs sampled at negedge.
  task automatic cyc(input string tag);
    @(posedge CK);
    model_step();
    @(negedge CK);
    check_all(tag);
  endtask

  initial begin
    RST = 1; start = 1; abort = 0; in_valid = 1; n466 = 1;
    num_patterns = 5; exp_sig = 16'hFFFF;

    // 1: reset dominates start and in_valid
    cyc("rst"); cyc("rst");
    check("rst_sig_c", 32'(signature), 32'h0);
    check("rst_ready_c", 32'(in_ready), 32'h0);
    RST = 0; start = 0; in_valid = 0; n466 = 0;
    cyc("idle");

    // 2: 1,0 -> 0x1021, 0x2042, pass
    start = 1; num_patterns = 2; exp_sig = 16'h2042; cyc("t2_start");
    start = 0; in_valid = 1; n466 = 1; cyc("t2_b0");
    check("t2_sig0_c", 32'(signature), 32'h1021);
    n466 = 0; cyc("t2_b1");
    in_valid = 0;
    check("t2_sig1_c", 32'(signature), 32'h2042);
    check("t2_done_c", 32'(done), 32'h1);
    check("t2_pass_c", 32'(pass), 32'h1);
    check("t2_ones_c", 32'(ones_cnt), 32'h1);
    cyc("t2_hold");

    // 3: 1,1 -> 0x3063 fails against 0x2042, then restart from DONE passes
    start = 1; num_patterns = 2; exp_sig = 16'h2042; cyc("t3_start");
    start = 0; in_valid = 1; n466 = 1; cyc("t3_b0"); cyc("t3_b1");
    in_valid = 0;
    check("t3_sig_c", 32'(signature), 32'h3063);
    check("t3_fail_c", 32'(pass), 32'h0);
    check("t3_ones_c", 32'(ones_cnt), 32'h2);
    start = 1; exp_sig = 16'h3063; cyc("t3_restart");
    start = 0; in_valid = 1; n466 = 1; cyc("t3_b2"); cyc("t3_b3");
    in_valid = 0;
    check("t3_pass_c", 32'(pass), 32'h1);

    // 4: zero-length run goes straight to DONE
    start = 1; num_patterns = 0; exp_sig = 16'h0000; cyc("t4_start");
    start = 0;
    check("t4_done_c", 32'(done), 32'h1);
    check("t4_pass_c", 32'(pass), 32'h1);
    check("t4_ready_c", 32'(in_ready), 32'h0);
    cyc("t4_hold");

    // 5: stall then abort with in_valid high
    start = 1; num_patterns = 3; exp_sig = 16'h1234; cyc("t5_start");
    start = 0; in_valid = 1; n466 = 1; cyc("t5_b0");
    in_valid = 0;
    for (int i = 0; i < 5; i++) cyc("t5_stall");
    abort = 1; in_valid = 1; cyc("t5_abort");
    abort = 0; in_valid = 0;
    check("t5_pat_c", 32'(pat_cnt), 32'h1);
    check("t5_sig_c", 32'(signature), 32'h1021);
    check("t5_busy_c", 32'(busy), 32'h0);
    check("t5_pass_c", 32'(pass), 32'h0);

    // 6: in_valid in the start cycle and start during RUN are both ignored
    start = 1; num_patterns = 1; exp_sig = 16'h0000; in_valid = 1; n466 = 1; cyc("t6_start");
    check("t6_pat0_c", 32'(pat_cnt), 32'h0);
    start = 1; in_valid = 0; num_patterns = 9; cyc("t6_restart_ign");
    check("t6_pat1_c", 32'(pat_cnt), 32'h0);
    check("t6_busy_c", 32'(busy), 32'h1);
    start = 0; in_valid = 1; n466 = 0; cyc("t6_b0");
    in_valid = 0;
    check("t6_done_c", 32'(done), 32'h1);
    check("t6_pat2_c", 32'(pat_cnt), 32'h1);
    check("t6_pass_c", 32'(pass), 32'h1);

    // Random traffic, including mid-run changes of num_patterns/exp_sig.
    for (int i = 0; i < 600; i++) begin
      RST          = ($urandom_range(0, 149) == 0);
      abort        = ($urandom_range(0, 39) == 0);
      start        = ($urandom_range(0, 7) == 0);
      in_valid     = $urandom_range(0, 1) == 1;
      n466         = $urandom_range(0, 1) == 1;
      num_patterns = 16'($urandom_range(0, 6));
      exp_sig      = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      cyc("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
